// File: rtl/ln_job_sequencer.sv
// ln_job_sequencer: FIFO-buffered job issuer for the maclaurin_box ln() engine.
// Queues x operands, issues one start pulse per job, holds x for the whole
// calculation, returns {ln, error, timeout} on a valid/ready slot, and turns
// a hung engine into a flagged result through a watchdog.
// Ports:
//   clk_clk, reset_reset          clock, async active-high reset
//   in_x/in_valid/in_ready        operand push (ready = FIFO not full)
//   out_ln/out_error/out_timeout  held result, qualified by out_valid
//   out_valid/out_ready           result handshake
//   box_x_export/box_start_export engine operand and start pulse
//   box_ln_export                 engine result
//   box_status_export             engine status {done, error}
//   busy, fifo_count              FSM activity and FIFO occupancy
module ln_job_sequencer #(
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 63
) (
   input  logic                          clk_clk,
   input  logic                          reset_reset,
   input  logic [31:0]                   in_x,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic [31:0]                   out_ln,
   output logic                          out_error,
   output logic                          out_timeout,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [31:0]                   box_x_export,
   output logic                          box_start_export,
   input  logic [31:0]                   box_ln_export,
   input  logic [1:0]                    box_status_export,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_WAIT_BUSY,
      S_WAIT_DONE
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [31:0]       r_mem [FIFO_DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;

   logic [15:0]       r_timer;
   logic [15:0]       w_timer_inc;
   logic [31:0]       r_x;
   logic [31:0]       r_ln;
   logic              r_err;
   logic              r_to;
   logic              r_valid;

   logic              w_in_ready;
   logic              w_push;
   logic              w_pop;
   logic              w_cap;
   logic              w_cap_to;
   logic              w_waiting;
   logic              w_timeout;
   logic              w_done;

   assign w_done      = box_status_export[1];
   assign w_in_ready  = (r_count != CW'(FIFO_DEPTH));
   assign w_push      = in_valid & w_in_ready;
   assign w_waiting   = (r_state == S_WAIT_BUSY) ||
                        (r_state == S_WAIT_DONE);
   // The timer holds the number of wait cycles already spent; the watchdog
   // fires in the cycle that brings the count up to TIMEOUT.
   assign w_timer_inc = r_timer + 16'd1;
   assign w_timeout   = w_waiting && (w_timer_inc == 16'(TIMEOUT));

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_cap       = 1'b0;
      w_cap_to    = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if ((r_count != '0) && !r_valid) begin
               w_pop       = 1'b1;
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            w_state_nxt = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (w_timeout) begin
               w_cap_to    = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (!w_done) begin
               w_state_nxt = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            // Watchdog wins over a done arriving in the same cycle.
            if (w_timeout) begin
               w_cap_to    = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (w_done) begin
               w_cap       = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Storage needs no reset: occupancy is tracked by the pointers.
   always_ff @(posedge clk_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= in_x;
      end
   end

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         r_timer <= '0;
      end else if (r_state == S_START) begin
         r_timer <= '0;
      end else if (w_waiting) begin
         r_timer <= w_timer_inc;
      end
   end

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         r_x <= '0;
      end else if (w_pop) begin
         r_x <= r_mem[r_rd_ptr];
      end
   end

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         r_ln    <= '0;
         r_err   <= 1'b0;
         r_to    <= 1'b0;
         r_valid <= 1'b0;
      end else if (w_cap_to) begin
         r_ln    <= '0;
         r_err   <= 1'b1;
         r_to    <= 1'b1;
         r_valid <= 1'b1;
      end else if (w_cap) begin
         r_ln    <= box_ln_export;
         r_err   <= box_status_export[0];
         r_to    <= 1'b0;
         r_valid <= 1'b1;
      end else if (r_valid && out_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign in_ready         = w_in_ready;
   assign fifo_count       = r_count;
   assign out_ln           = r_ln;
   assign out_error        = r_err;
   assign out_timeout      = r_to;
   assign out_valid        = r_valid;
   assign box_x_export     = r_x;
   assign box_start_export = (r_state == S_START);
   assign busy             = (r_state != S_IDLE);

endmodule

// File: tb/tb_ln_job_sequencer.sv
// tb_ln_job_sequencer: directed bench for ln_job_sequencer with a
// behavioural engine (done falls after start, rises D cycles later).
module tb_ln_job_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] in_x = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] out_ln;
   logic        out_error;
   logic        out_timeout;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] box_x;
   logic        box_start;
   logic [31:0] box_ln;
   logic [1:0]  box_status;
   logic        busy;
   logic [2:0]  fifo_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ln_job_sequencer #(.FIFO_DEPTH(4), .TIMEOUT(63)) dut (
      .clk_clk           (clk),
      .reset_reset       (reset),
      .in_x              (in_x),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .out_ln            (out_ln),
      .out_error         (out_error),
      .out_timeout       (out_timeout),
      .out_valid         (out_valid),
      .out_ready         (out_ready),
      .box_x_export      (box_x),
      .box_start_export  (box_start),
      .box_ln_export     (box_ln),
      .box_status_export (box_status),
      .busy              (busy),
      .fifo_count        (fifo_count)
   );

   // Behavioural engine: not reset by the DUT reset.
   logic        eng_done = 1'b1;
   logic        eng_err = 1'b0;
   logic [31:0] eng_ln = '0;
   logic        eng_seen = 1'b0;
   logic        eng_run = 1'b0;
   logic        eng_hang = 1'b0;
   int          eng_cnt = 0;
   int          eng_d = 35;
   logic        hang_next = 1'b0;

   assign box_ln     = eng_ln;
   assign box_status = {eng_done, eng_err};

   always @(posedge clk) begin
      if (eng_seen) begin
         eng_seen <= 1'b0;
         eng_done <= 1'b0;
         eng_cnt  <= eng_d;
         eng_run  <= 1'b1;
         eng_hang <= hang_next;
      end else if (eng_run) begin
         if (eng_cnt == 1) begin
            eng_run <= 1'b0;
            if (!eng_hang) begin
               eng_done <= 1'b1;
               eng_ln   <= box_x + 32'd1;
               eng_err  <= box_x[31];
            end
         end else begin
            eng_cnt <= eng_cnt - 1;
         end
      end
      if (box_start) eng_seen <= 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   typedef struct packed {
      logic [31:0] ln;
      logic        err;
      logic        to;
   } res_t;

   res_t exp_q[$];
   res_t got;
   int   starts = 0;
   logic prev_start = 1'b0;
   logic prev_busy = 1'b0;
   logic [31:0] prev_x = '0;

   // Scoreboard and operand-hold monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (box_start) begin
         starts++;
         chk("start_single_cycle", 32'(prev_start), 32'd0);
      end
      if (busy && prev_busy) chk("x_hold", box_x, prev_x);
      if (!reset && out_valid && out_ready) begin
         chk("result_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            got = exp_q.pop_front();
            chk("res_ln", out_ln, got.ln);
            chk("res_err", 32'(out_error), 32'(got.err));
            chk("res_to", 32'(out_timeout), 32'(got.to));
         end
      end
      prev_start = box_start;
      prev_busy  = busy;
      prev_x     = box_x;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain(input int maxc);
      int n = 0;
      while ((exp_q.size() != 0 || busy || fifo_count != 0) && n < maxc) begin
         step(1);
         n++;
      end
      chk("drain_in_time", 32'(n < maxc), 32'd1);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_ready"}, 32'(in_ready), 32'd1);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_count"}, 32'(fifo_count), 32'd0);
      chk({tag, "_start"}, 32'(box_start), 32'd0);
      chk({tag, "_x"}, box_x, 32'd0);
      chk({tag, "_ln"}, out_ln, 32'd0);
      chk({tag, "_err"}, 32'(out_error), 32'd0);
      chk({tag, "_to"}, 32'(out_timeout), 32'd0);
   endtask

   // Push one operand into an idle, empty block and check when out_valid rises.
   task automatic timed_job(input logic [31:0] x, input int d,
                            input int lat, input res_t r);
      eng_d = d;
      exp_q.push_back(r);
      in_x = x;
      in_valid = 1'b1;
      step(1);
      in_valid = 1'b0;
      step(lat - 2);
      chk("lat_before", 32'(out_valid), 32'd0);
      step(1);
      chk("lat_valid", 32'(out_valid), 32'd1);
      chk("lat_to", 32'(out_timeout), 32'(r.to));
      drain(200);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      int s0;
      int n;
      #2;
      chk_reset_vals("reset");
      step(2);
      reset = 1'b0;
      step(1);

      // Single job: start pulse in c+2, result in c+40.
      s0 = starts;
      eng_d = 35;
      exp_q.push_back('{32'h11, 1'b0, 1'b0});
      in_x = 32'h10;
      in_valid = 1'b1;
      chk("t1_in_ready", 32'(in_ready), 32'd1);
      step(1);
      in_valid = 1'b0;
      chk("t1_no_start_c1", 32'(box_start), 32'd0);
      step(1);
      chk("t1_start_c2", 32'(box_start), 32'd1);
      chk("t1_x", box_x, 32'h10);
      step(1);
      chk("t1_start_low_c3", 32'(box_start), 32'd0);
      chk("t1_one_start", 32'(starts - s0), 32'd1);
      step(36);
      chk("t1_valid_c39", 32'(out_valid), 32'd0);
      step(1);
      chk("t1_valid_c40", 32'(out_valid), 32'd1);
      chk("t1_ln_c40", out_ln, 32'h11);
      step(1);
      chk("t1_consumed", 32'(out_valid), 32'd0);
      drain(100);

      // Back-to-back: four pushes, occupancy peaks at 3.
      for (int i = 0; i < 4; i++) begin
         in_x = 32'h100 + 32'(i);
         in_valid = 1'b1;
         chk("t2_in_ready", 32'(in_ready), 32'd1);
         exp_q.push_back('{32'h101 + 32'(i), 1'b0, 1'b0});
         step(1);
      end
      in_valid = 1'b0;
      chk("t2_peak_count", 32'(fifo_count), 32'd3);
      drain(300);

      // Full FIFO with the output stalled.
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         exp_q.push_back('{32'h201 + 32'(i), 1'b0, 1'b0});
      end
      for (int i = 0; i < 5; i++) begin
         in_x = 32'h200 + 32'(i);
         in_valid = 1'b1;
         chk("t3_in_ready", 32'(in_ready), 32'd1);
         step(1);
      end
      in_valid = 1'b0;
      chk("t3_full_ready", 32'(in_ready), 32'd0);
      chk("t3_full_count", 32'(fifo_count), 32'd4);
      in_x = 32'h205;
      in_valid = 1'b1;
      step(45);
      chk("t3_held_valid", 32'(out_valid), 32'd1);
      chk("t3_held_ln", out_ln, 32'h201);
      chk("t3_held_ready", 32'(in_ready), 32'd0);
      chk("t3_held_count", 32'(fifo_count), 32'd4);
      out_ready = 1'b1;
      n = 0;
      while (!in_ready && n < 100) begin
         step(1);
         n++;
      end
      chk("t3_space_freed", 32'(n < 100), 32'd1);
      step(1);
      in_valid = 1'b0;
      drain(500);

      // Error propagation.
      timed_job(32'h8000_0000, 35, 40, '{32'h8000_0001, 1'b1, 1'b0});

      // Watchdog on a hung job, followed by a normal queued job.
      hang_next = 1'b1;
      exp_q.push_back('{32'h0, 1'b1, 1'b1});
      exp_q.push_back('{32'h22, 1'b0, 1'b0});
      in_x = 32'h20;
      in_valid = 1'b1;
      step(1);
      in_x = 32'h21;
      step(1);
      in_valid = 1'b0;
      step(63);
      chk("t5_valid_c65", 32'(out_valid), 32'd0);
      step(1);
      chk("t5_valid_c66", 32'(out_valid), 32'd1);
      chk("t5_to_c66", 32'(out_timeout), 32'd1);
      hang_next = 1'b0;
      drain(200);

      // Done one cycle before the watchdog, then coincident with it.
      timed_job(32'h30, 60, 65, '{32'h31, 1'b0, 1'b0});
      timed_job(32'h31, 61, 66, '{32'h0, 1'b1, 1'b1});

      // Reset during WAIT_DONE: job dropped, late done ignored.
      eng_d = 35;
      in_x = 32'h40;
      in_valid = 1'b1;
      step(1);
      in_valid = 1'b0;
      step(9);
      chk("t6_busy_before", 32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      chk_reset_vals("midreset");
      step(2);
      reset = 1'b0;
      step(60);
      chk("t6_no_stale", 32'(out_valid), 32'd0);
      chk("t6_idle", 32'(busy), 32'd0);
      timed_job(32'h50, 35, 40, '{32'h51, 1'b0, 1'b0});

      chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
